// File: rtl/irq_arb_pkg.sv
// Shared state encoding, widths and vector-slice helper for the vectored interrupt arbiter.
package irq_arb_pkg;

  localparam int unsigned VEC_W   = 16;
  localparam int unsigned MAX_SRC = 16;
  localparam int unsigned ALL_W   = VEC_W * MAX_SRC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    REL  = 2'd3
  } arb_state_e;

  // Vector of device k from a bus padded out to MAX_SRC slices.
  function automatic logic [VEC_W-1:0] vec_slice(input logic [ALL_W-1:0] vecs,
                                                 input logic [3:0]       k);
    return VEC_W'(vecs >> (32'(k) * VEC_W));
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Rotating priority encoder: first set request at or above i_start, wrapping modulo NUM_SRC.
module irq_prio_enc #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [IDX_W-1:0]   i_start,
  output logic               o_valid_c,
  output logic [IDX_W-1:0]   o_idx_c
);

  int unsigned          w_pos;
  logic [NUM_SRC-1:0]   w_rot;

  always_comb begin
    o_valid_c = 1'b0;
    o_idx_c   = '0;
    w_pos     = 0;
    w_rot     = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      w_pos = (32'(i_start) + i) % NUM_SRC;
      w_rot = i_req >> w_pos;
      if (!o_valid_c && w_rot[0]) begin
        o_valid_c = 1'b1;
        o_idx_c   = IDX_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/irq_vector_arbiter.sv
// Shares one CPU virq/istb/iack handshake among NUM_SRC irq/iack peripherals.
// Define IRQ_ARB_ROUND_ROBIN_EN for rotating priority; default build is fixed (lowest index wins).
module irq_vector_arbiter
  import irq_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC  = 4,
  parameter logic [15:0] SPUR_VEC = 16'o000000
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [NUM_SRC-1:0]       dev_irq_i,
  output logic [NUM_SRC-1:0]       dev_iack_o,
  input  logic [VEC_W*NUM_SRC-1:0] dev_vec_i,
  output logic                     cpu_virq_o,
  input  logic                     cpu_istb_i,
  output logic [VEC_W-1:0]         cpu_ivec_o,
  output logic                     cpu_iack_o
);

  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  arb_state_e         r_state;
  logic [NUM_SRC-1:0] r_irq_q;
  logic [IDX_W-1:0]   r_grant;
  logic [IDX_W-1:0]   w_start;
  logic [IDX_W-1:0]   w_idx;
  logic               w_valid;
  logic [ALL_W-1:0]   w_vec_all;
  logic [VEC_W-1:0]   w_grant_vec;
  logic [NUM_SRC-1:0] w_grant_onehot;
  logic               w_grant_live;

`ifdef IRQ_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]   r_rr_ptr;
  assign w_start = r_rr_ptr;
`else
  assign w_start = '0;
`endif

  assign w_vec_all      = ALL_W'(dev_vec_i);
  assign w_grant_vec    = vec_slice(w_vec_all, 4'(r_grant));
  assign w_grant_onehot = NUM_SRC'(1) << r_grant;
  assign w_grant_live   = |(r_irq_q & w_grant_onehot);

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_prio_enc (
    .i_req     (r_irq_q),
    .i_start   (w_start),
    .o_valid_c (w_valid),
    .o_idx_c   (w_idx)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state    <= IDLE;
      r_irq_q    <= '0;
      r_grant    <= '0;
      dev_iack_o <= '0;
      cpu_virq_o <= 1'b0;
      cpu_iack_o <= 1'b0;
      cpu_ivec_o <= '0;
`ifdef IRQ_ARB_ROUND_ROBIN_EN
      r_rr_ptr   <= '0;
`endif
    end else begin
      r_irq_q <= dev_irq_i;
      case (r_state)
        // A strobe with nothing granted is a stale CPU read: answer it spuriously.
        IDLE: begin
          if (cpu_istb_i) begin
            dev_iack_o <= '0;
            cpu_iack_o <= 1'b1;
            cpu_ivec_o <= SPUR_VEC;
            cpu_virq_o <= 1'b0;
            r_state    <= ACK;
          end else if (w_valid) begin
            r_grant    <= w_idx;
            cpu_virq_o <= 1'b1;
            r_state    <= REQ;
          end
        end
        REQ: begin
          if (cpu_istb_i) begin
            cpu_virq_o <= 1'b0;
            cpu_iack_o <= 1'b1;
            if (w_grant_live) begin
              dev_iack_o <= w_grant_onehot;
              cpu_ivec_o <= w_grant_vec;
            end else begin
              dev_iack_o <= '0;
              cpu_ivec_o <= SPUR_VEC;
            end
            r_state <= ACK;
          end else if (!w_grant_live) begin
            cpu_virq_o <= 1'b0;
            r_state    <= IDLE;
          end
        end
        ACK: r_state <= REL;
        // Devices see iack fall before any re-arbitration happens.
        REL: begin
          if (!cpu_istb_i) begin
            dev_iack_o <= '0;
            cpu_iack_o <= 1'b0;
            r_state    <= IDLE;
`ifdef IRQ_ARB_ROUND_ROBIN_EN
            if (|dev_iack_o) begin
              r_rr_ptr <= (r_grant == IDX_W'(NUM_SRC - 1)) ? '0 : r_grant + IDX_W'(1);
            end
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_vector_arbiter.sv
// Self-checking bench for irq_vector_arbiter: cycle table, directed corner sequences, and a
// randomized run with protocol-following devices/CPU checked against a transaction-level model.
module tb_irq_vector_arbiter;

  localparam int unsigned N    = 4;
  localparam logic [15:0] SPUR = 16'o000000;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic [N-1:0]  dev_irq_i;
  logic [N-1:0]  dev_iack_o;
  logic [16*N-1:0] dev_vec_i;
  logic          cpu_virq_o;
  logic          cpu_istb_i;
  logic [15:0]   cpu_ivec_o;
  logic          cpu_iack_o;

  int n_cmp = 0;
  int n_err = 0;

  irq_vector_arbiter #(.NUM_SRC(N), .SPUR_VEC(SPUR)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .dev_irq_i  (dev_irq_i),
    .dev_iack_o (dev_iack_o),
    .dev_vec_i  (dev_vec_i),
    .cpu_virq_o (cpu_virq_o),
    .cpu_istb_i (cpu_istb_i),
    .cpu_ivec_o (cpu_ivec_o),
    .cpu_iack_o (cpu_iack_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [3:0]  irq;
    logic        istb;
    logic        virq;
    logic        iack;
    logic [3:0]  dev;
    logic [15:0] vec;
    logic        chk_vec;
  } row_t;

  row_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge wb_clk_i);
  endtask

  task automatic do_reset();
    wb_rst_i   = 1'b1;
    dev_irq_i  = '0;
    cpu_istb_i = 1'b0;
    tick();
    wb_rst_i = 1'b0;
    tick();
  endtask

  function automatic logic [3:0] onehot(input int k);
    return (k < 0) ? 4'b0000 : 4'(4'd1 << k);
  endfunction

  function automatic logic [15:0] vec_of(input int k);
    return (k < 0 || k >= int'(N)) ? 16'hdead : 16'(dev_vec_i >> (16 * k));
  endfunction

  // First requester at or after position p, wrapping.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < int'(N); i++) begin
      int k;
      k = (p + i) % int'(N);
      if (((r >> k) & 4'd1) != 4'd0) return k;
    end
    return -1;
  endfunction

  logic [3:0] p1, p2, irq_next;
  int dst[N];
  int cst, cdelay, chold, ctimer, winner, ptr, hs, rr_exp, w;
  logic prev_virq, prev_iack;

  initial begin
    tbl[0]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000, 16'o000000, 1'b0};
    tbl[1]  = '{4'b0100, 1'b0, 1'b1, 1'b0, 4'b0000, 16'o000000, 1'b0};
    tbl[2]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100, 16'o000300, 1'b1};
    tbl[3]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100, 16'o000300, 1'b1};
    tbl[4]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100, 16'o000300, 1'b1};
    tbl[5]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 16'o000000, 1'b0};
    tbl[6]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 16'o000000, 1'b0};
    tbl[7]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, SPUR,       1'b1};
    tbl[8]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, SPUR,       1'b1};
    tbl[9]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 16'o000000, 1'b0};
    tbl[10] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 16'o000000, 1'b0};

    dev_vec_i  = {16'o000400, 16'o000300, 16'o000200, 16'o000100};
    wb_rst_i   = 1'b1;
    dev_irq_i  = '0;
    cpu_istb_i = 1'b0;
    tick();
    check("reset virq", 32'(cpu_virq_o), 32'd0);
    check("reset cpu_iack", 32'(cpu_iack_o), 32'd0);
    check("reset dev_iack", 32'(dev_iack_o), 32'd0);
    check("reset ivec", 32'(cpu_ivec_o), 32'd0);
    wb_rst_i = 1'b0;
    tick();

    // Single handshake, then a stale strobe answered spuriously.
    for (int i = 0; i < 11; i++) begin
      dev_irq_i  = tbl[i].irq;
      cpu_istb_i = tbl[i].istb;
      tick();
      check($sformatf("tbl%0d virq", i), 32'(cpu_virq_o), 32'(tbl[i].virq));
      check($sformatf("tbl%0d cpu_iack", i), 32'(cpu_iack_o), 32'(tbl[i].iack));
      check($sformatf("tbl%0d dev_iack", i), 32'(dev_iack_o), 32'(tbl[i].dev));
      if (tbl[i].chk_vec) check($sformatf("tbl%0d ivec", i), 32'(cpu_ivec_o), 32'(tbl[i].vec));
    end

    // Two simultaneous requests: dev1 first, dev3 after dev1 drops.
    do_reset();
    dev_irq_i = 4'b1010;
    tick();
    check("sim virq +1", 32'(cpu_virq_o), 32'd0);
    tick();
    check("sim virq +2", 32'(cpu_virq_o), 32'd1);
    cpu_istb_i = 1'b1;
    tick();
    check("sim dev1 iack", 32'(dev_iack_o), 32'b0010);
    check("sim dev1 vec", 32'(cpu_ivec_o), 32'(16'o000200));
    dev_irq_i  = 4'b1000;
    cpu_istb_i = 1'b0;
    tick();
    tick();
    check("sim release", 32'(dev_iack_o), 32'd0);
    tick();
    check("sim dev3 virq", 32'(cpu_virq_o), 32'd1);
    cpu_istb_i = 1'b1;
    tick();
    check("sim dev3 iack", 32'(dev_iack_o), 32'b1000);
    check("sim dev3 vec", 32'(cpu_ivec_o), 32'(16'o000400));
    cpu_istb_i = 1'b0;
    dev_irq_i  = '0;
    tick();
    tick();
    check("sim final cpu_iack", 32'(cpu_iack_o), 32'd0);

    // Withdrawn request in REQ: virq falls, then dev2 is arbitrated.
    do_reset();
    dev_irq_i = 4'b0001;
    tick();
    tick();
    check("wd virq dev0", 32'(cpu_virq_o), 32'd1);
    dev_irq_i = 4'b0100;
    tick();
    check("wd virq hold", 32'(cpu_virq_o), 32'd1);
    tick();
    check("wd virq drop", 32'(cpu_virq_o), 32'd0);
    tick();
    check("wd virq dev2", 32'(cpu_virq_o), 32'd1);
    cpu_istb_i = 1'b1;
    tick();
    check("wd dev2 iack", 32'(dev_iack_o), 32'b0100);
    check("wd dev2 vec", 32'(cpu_ivec_o), 32'(16'o000300));
    cpu_istb_i = 1'b0;
    dev_irq_i  = '0;
    tick();
    tick();
    check("wd final cpu_iack", 32'(cpu_iack_o), 32'd0);

    // Asynchronous reset in REL.
    do_reset();
    dev_irq_i = 4'b0010;
    tick();
    tick();
    cpu_istb_i = 1'b1;
    tick();
    tick();
    check("ar dev_iack before", 32'(dev_iack_o), 32'b0010);
    #2 wb_rst_i = 1'b1;
    #1;
    check("ar dev_iack", 32'(dev_iack_o), 32'd0);
    check("ar cpu_iack", 32'(cpu_iack_o), 32'd0);
    check("ar virq", 32'(cpu_virq_o), 32'd0);
    tick();
    wb_rst_i   = 1'b0;
    cpu_istb_i = 1'b0;
    dev_irq_i  = 4'b0001;
    tick();
    check("ar idle +1", 32'(cpu_virq_o), 32'd0);
    tick();
    check("ar idle +2", 32'(cpu_virq_o), 32'd1);

    // All requests held: five handshakes.
    do_reset();
    dev_irq_i = 4'b1111;
    for (int h = 0; h < 5; h++) begin
`ifdef IRQ_ARB_ROUND_ROBIN_EN
      rr_exp = h % int'(N);
`else
      rr_exp = 0;
`endif
      w = 0;
      while (!cpu_virq_o && w < 10) begin
        tick();
        w++;
      end
      check($sformatf("all%0d virq", h), 32'(cpu_virq_o), 32'd1);
      cpu_istb_i = 1'b1;
      tick();
      check($sformatf("all%0d grant", h), 32'(dev_iack_o), 32'(onehot(rr_exp)));
      cpu_istb_i = 1'b0;
      tick();
      tick();
    end

    // Randomized run with protocol-following devices and CPU.
    do_reset();
    for (int k = 0; k < int'(N); k++) begin
      dev_vec_i[16*k +: 16] = 16'($urandom);
      dst[k] = 0;
    end
    p1 = '0; p2 = '0; irq_next = '0;
    cst = 0; cdelay = 0; chold = 0; ctimer = 0;
    winner = -1; ptr = 0; hs = 0;
    prev_virq = 1'b0; prev_iack = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      check("rnd iack onehot", 32'($countones(dev_iack_o) <= 1), 32'd1);
      if (cpu_virq_o && !prev_virq) winner = pick(p2, ptr);
      if (cpu_iack_o && !prev_iack) begin
        check("rnd grant", 32'(dev_iack_o), 32'(onehot(winner)));
        check("rnd vec", 32'(cpu_ivec_o), 32'(vec_of(winner)));
        hs++;
`ifdef IRQ_ARB_ROUND_ROBIN_EN
        if (winner >= 0) ptr = (winner + 1) % int'(N);
`endif
      end
      prev_virq = cpu_virq_o;
      prev_iack = cpu_iack_o;

      for (int k = 0; k < int'(N); k++) begin
        case (dst[k])
          0: if ($urandom_range(7) == 0) begin irq_next[k] = 1'b1; dst[k] = 1; end
          1: if (dev_iack_o[k]) begin irq_next[k] = 1'b0; dst[k] = 2; end
          default: if (!dev_iack_o[k]) dst[k] = 0;
        endcase
      end

      case (cst)
        0: if (cpu_virq_o) begin
             cdelay = int'($urandom_range(3));
             ctimer = 0;
             if (cdelay == 0) begin cpu_istb_i = 1'b1; cst = 2; end
             else cst = 1;
           end
        1: begin
             cdelay--;
             if (cdelay <= 0) begin cpu_istb_i = 1'b1; cst = 2; end
           end
        2: begin
             ctimer++;
             if (cpu_iack_o) begin
               chold = int'($urandom_range(2));
               ctimer = 0;
               if (chold == 0) begin cpu_istb_i = 1'b0; cst = 4; end
               else cst = 3;
             end else if (ctimer > 8) begin
               check("rnd iack wait", 32'(cpu_iack_o), 32'd1);
               cpu_istb_i = 1'b0;
               ctimer = 0;
               cst = 4;
             end
           end
        3: begin
             chold--;
             if (chold <= 0) begin cpu_istb_i = 1'b0; ctimer = 0; cst = 4; end
           end
        default: begin
             ctimer++;
             if (!cpu_iack_o) cst = 0;
             else if (ctimer > 8) begin
               check("rnd iack release", 32'(cpu_iack_o), 32'd0);
               cst = 0;
             end
           end
      endcase

      dev_irq_i = irq_next;
      p2 = p1;
      p1 = irq_next;
    end
    check("rnd handshake count", 32'(hs >= 50), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
